mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the processor's single memory port (mem_read / mem_write / mem_address / data_out / data_in) between two requesters: the instruction-fetch unit (IF) and the data-memory unit (DM).
- Each requester uses a req/ack handshake. The arbiter grants one requester at a time using 2-way round-robin, drives a one-cycle memory strobe, and waits a fixed memory latency. It then returns read data with a one-cycle ack.
- Sits between the processor core and the external 16-bit memory.

Parameters:
- DATA_W, 16, data width of all data buses
- ADDR_W, 16, address width
- MEM_LAT, 1, cycles from the strobe cycle to the cycle in which data_in is valid; legal range 1..15, and 0 is illegal

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held high until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle completion pulse
- if_rdata  out  DATA_W  fetched word; valid while if_ack is high and held until the next IF read
- dm_req  in  1  data request; held high until dm_ack
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_ack  out  1  one-cycle completion pulse
- dm_rdata  out  DATA_W  read word; valid with dm_ack and held until the next DM read
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_W  memory address
- data_out  out  DATA_W  memory write data
- data_in  in  DATA_W  memory read data
- busy  out  1  high in every state except IDLE
- grant_id  out  1  0 = IF, 1 = DM; the current or last granted requester

Behaviour:
- Reset (asynchronous):
  - state = IDLE; all outputs are 0.
  - last_grant = DM, so the first tie goes to IF.
  - Lat counter = 0.
  - An in-flight access is abandoned and no ack is issued for it.
- FSM states: IDLE, STROBE, WAIT, RESP.
- IDLE:
  - If no request, stay in IDLE.
  - If only one req is high, grant that requester.
  - If both are high, grant the requester that is not last_grant.
  - On grant: latch addr, we (IF always reads), and wdata into internal registers; update last_grant and grant_id; go to STROBE.
- STROBE (exactly 1 cycle):
  - mem_address = latched address.
  - mem_read = !we, mem_write = we.
  - data_out = latched wdata for writes, 0 for reads.
  - Load the lat counter with MEM_LAT-1.
  - Go to WAIT.
- Memory outputs outside STROBE: mem_read and mem_write are 0. mem_address and data_out hold their last values; they are registered outputs, not combinational.
- WAIT:
  - If counter == 0: sample data_in into the granted requester's rdata register (reads only) and go to RESP.
  - Otherwise decrement the counter.
- RESP (1 cycle):
  - The granted requester's ack = 1; the other ack = 0.
  - Request inputs are ignored in this cycle.
  - Next state is IDLE.
- Timing:
  - If req is high at edge E0 in IDLE, the STROBE cycle follows E0, data_in is sampled at edge E0+1+MEM_LAT, and ack is high in the cycle after that edge.
  - Request-to-ack latency is MEM_LAT+2 cycles. Back-to-back throughput is one access per MEM_LAT+3 cycles.
- Writes: ack is issued, and dm_rdata is unchanged.
- Requester inputs changing after grant have no effect until the next grant.
- A req dropped before ack is a protocol violation: the access still completes and ack still pulses.
- Starvation bound: with both requesters held continuously, grants alternate strictly IF, DM, IF, DM, …

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, STROBE, WAIT, RESP);
  - requester ID constants REQ_IF = 1'b0 and REQ_DM = 1'b1;
  - the MEM_LAT legality check as an elaboration-time assertion.
- One sub-module, rr_arb2. It is combinational: inputs are two reqs and last_grant; outputs are grant_valid and grant_id. It is reused later for other 2-way shared resources.

Test Plan:
- IF-only read: if_req=1, if_addr=0x0010, data_in=0xBEEF at the sample edge (MEM_LAT=1). Expected: mem_read pulse of one cycle with mem_address=0x0010, then if_ack in the 3rd cycle after req with if_rdata=0xBEEF, then busy=0.
- DM write: dm_req=1, dm_we=1, dm_addr=0x0200, dm_wdata=0x1234. Expected: one-cycle mem_write with data_out=0x1234 and mem_address=0x0200; mem_read stays 0; dm_ack pulses; dm_rdata is unchanged.
- Simultaneous requests after reset, both held for 4 accesses. Expected: grant_id sequence 0, 1, 0, 1 and strictly alternating acks, each access MEM_LAT+3 cycles apart.
- MEM_LAT=4: DM read of 0x0300 with data_in=0xA5A5 valid only in the 4th cycle after the strobe and 0xFFFF otherwise. Expected: dm_rdata=0xA5A5 and ack in the 6th cycle after req.
- Reset asserted in WAIT, mid-access. Expected: all outputs are 0 immediately (asynchronous); no ack follows; after release, a fresh if_req completes normally.
- Address changed after grant: if_addr changes from 0x0040 to 0x0050 during WAIT. Expected: mem_address remained 0x0040 and the rdata belongs to the 0x0040 access.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter and its round-robin helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;

  function automatic bit mem_lat_legal(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker; on a tie the side that did not win last time wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_id = ~last_grant;
    end else if (req1) begin
      grant_id = REQ_DM;
    end else begin
      grant_id = REQ_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data memory: one strobe cycle,
// a fixed latency wait, then a one-cycle ack to the granted requester.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              grant_id
);

  if (!mem_lat_legal(MEM_LAT)) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be within 1..15");
  end

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  arb_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_id_q, grant_id_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic arb_valid;
  logic arb_id;
  logic grant_we;

  rr_arb2 u_rr_arb2 (
    .req0        (if_req),
    .req1        (dm_req),
    .last_grant  (last_grant_q),
    .grant_valid (arb_valid),
    .grant_id    (arb_id)
  );

  assign grant_we = (arb_id == REQ_DM) && dm_we;

  // Address/data are loaded at grant so they are already registered during STROBE.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    we_d          = we_q;
    mem_address_d = mem_address_q;
    data_out_d    = data_out_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    if_rdata_d    = if_rdata_q;
    dm_rdata_d    = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_id_d    = arb_id;
          last_grant_d  = arb_id;
          we_d          = grant_we;
          mem_address_d = (arb_id == REQ_DM) ? dm_addr : if_addr;
          data_out_d    = grant_we ? dm_wdata : '0;
          mem_read_d    = ~grant_we;
          mem_write_d   = grant_we;
          state_d       = STROBE;
        end
      end
      STROBE: begin
        cnt_d   = LAT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (grant_id_q == REQ_DM) dm_rdata_d = data_in;
            else                      if_rdata_d = data_in;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      last_grant_q  <= REQ_DM;
      grant_id_q    <= 1'b0;
      we_q          <= 1'b0;
      mem_address_q <= '0;
      data_out_q    <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      if_rdata_q    <= '0;
      dm_rdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      we_q          <= we_d;
      mem_address_q <= mem_address_d;
      data_out_q    <= data_out_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      if_rdata_q    <= if_rdata_d;
      dm_rdata_q    <= dm_rdata_d;
    end
  end

  assign if_ack      = (state_q == RESP) && (grant_id_q == REQ_IF);
  assign dm_ack      = (state_q == RESP) && (grant_id_q == REQ_DM);
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign data_out    = data_out_q;
  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random-stimulus bench for mem_port_arbiter at MEM_LAT=1 and MEM_LAT=4 against a
// transaction-timeline reference model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req   [2];
  logic [15:0] if_addr  [2];
  logic        if_ack   [2];
  logic [15:0] if_rdata [2];
  logic        dm_req   [2];
  logic        dm_we    [2];
  logic [15:0] dm_addr  [2];
  logic [15:0] dm_wdata [2];
  logic        dm_ack   [2];
  logic [15:0] dm_rdata [2];
  logic        mem_read [2];
  logic        mem_write[2];
  logic [15:0] mem_address[2];
  logic [15:0] data_out [2];
  logic [15:0] din      [2];
  logic        busy     [2];
  logic        grant_id [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .DATA_W (16),
      .ADDR_W (16),
      .MEM_LAT((g == 0) ? 1 : 4)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .if_req     (if_req[g]),
      .if_addr    (if_addr[g]),
      .if_ack     (if_ack[g]),
      .if_rdata   (if_rdata[g]),
      .dm_req     (dm_req[g]),
      .dm_we      (dm_we[g]),
      .dm_addr    (dm_addr[g]),
      .dm_wdata   (dm_wdata[g]),
      .dm_ack     (dm_ack[g]),
      .dm_rdata   (dm_rdata[g]),
      .mem_read   (mem_read[g]),
      .mem_write  (mem_write[g]),
      .mem_address(mem_address[g]),
      .data_out   (data_out[g]),
      .data_in    (din[g]),
      .busy       (busy[g]),
      .grant_id   (grant_id[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: an access granted at edge t strobes in the cycle after t,
  // samples data_in at edge t+1+LAT, acks after that edge, and frees the port at t+2+LAT.
  bit          m_busy [2];
  int          m_tg   [2];
  bit          m_gid  [2];
  bit          m_last [2];
  bit          m_we   [2];
  logic [15:0] m_addr [2];
  logic [15:0] m_dout [2];
  logic [15:0] m_if_rd[2];
  logic [15:0] m_dm_rd[2];
  bit          if_on  [2];
  bit          dm_on  [2];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_reset(input int d);
    m_busy[d]  = 1'b0;
    m_tg[d]    = 0;
    m_gid[d]   = 1'b0;
    m_last[d]  = 1'b1;
    m_we[d]    = 1'b0;
    m_addr[d]  = '0;
    m_dout[d]  = '0;
    m_if_rd[d] = '0;
    m_dm_rd[d] = '0;
  endtask

  task automatic model_edge(input int d);
    int k;
    bit w;
    if (m_busy[d]) begin
      k = cyc - m_tg[d];
      if (k == 1 + lat_of(d) && !m_we[d]) begin
        if (m_gid[d]) m_dm_rd[d] = din[d];
        else          m_if_rd[d] = din[d];
      end
      if (k == 2 + lat_of(d)) m_busy[d] = 1'b0;
    end else if (if_req[d] || dm_req[d]) begin
      if (if_req[d] && dm_req[d]) w = ~m_last[d];
      else                        w = dm_req[d];
      m_busy[d] = 1'b1;
      m_tg[d]   = cyc;
      m_gid[d]  = w;
      m_last[d] = w;
      m_we[d]   = w && dm_we[d];
      m_addr[d] = w ? dm_addr[d] : if_addr[d];
      m_dout[d] = m_we[d] ? dm_wdata[d] : 16'h0000;
    end
  endtask

  function automatic bit exp_strobe(input int d);
    return m_busy[d] && (cyc - m_tg[d] == 0);
  endfunction

  function automatic bit exp_ack(input int d);
    return m_busy[d] && (cyc - m_tg[d] == 1 + lat_of(d));
  endfunction

  task automatic check_cycle(input int d);
    string p;
    p = $sformatf("L%0d.", lat_of(d));
    check_eq({p, "mem_read"},    mem_read[d],    exp_strobe(d) && !m_we[d]);
    check_eq({p, "mem_write"},   mem_write[d],   exp_strobe(d) && m_we[d]);
    check_eq({p, "mem_address"}, mem_address[d], m_addr[d]);
    check_eq({p, "data_out"},    data_out[d],    m_dout[d]);
    check_eq({p, "if_ack"},      if_ack[d],      exp_ack(d) && !m_gid[d]);
    check_eq({p, "dm_ack"},      dm_ack[d],      exp_ack(d) && m_gid[d]);
    check_eq({p, "if_rdata"},    if_rdata[d],    m_if_rd[d]);
    check_eq({p, "dm_rdata"},    dm_rdata[d],    m_dm_rd[d]);
    check_eq({p, "busy"},        busy[d],        m_busy[d]);
    check_eq({p, "grant_id"},    grant_id[d],    m_gid[d]);
  endtask

  task automatic drive_next(input int d, input int prob);
    bit sample_next;
    if (if_on[d] && exp_ack(d) && !m_gid[d]) begin
      if_on[d] = 1'b0; if_req[d] = 1'b0;
    end
    if (dm_on[d] && exp_ack(d) && m_gid[d]) begin
      dm_on[d] = 1'b0; dm_req[d] = 1'b0;
    end
    if (!if_on[d] && int'($urandom_range(99)) < prob) begin
      if_on[d] = 1'b1; if_req[d] = 1'b1; if_addr[d] = 16'($urandom);
    end else if (if_on[d] && $urandom_range(9) == 0) begin
      if_addr[d] = 16'($urandom);
    end
    if (!dm_on[d] && int'($urandom_range(99)) < prob) begin
      dm_on[d] = 1'b1; dm_req[d] = 1'b1;
      dm_we[d] = 1'($urandom); dm_addr[d] = 16'($urandom); dm_wdata[d] = 16'($urandom);
    end else if (dm_on[d] && $urandom_range(9) == 0) begin
      dm_we[d] = 1'($urandom); dm_addr[d] = 16'($urandom); dm_wdata[d] = 16'($urandom);
    end
    sample_next = m_busy[d] && (cyc + 1 - m_tg[d] == 1 + lat_of(d));
    if (d == 0 || sample_next) din[d] = 16'($urandom);
    else                       din[d] = 16'hFFFF;
  endtask

  task automatic clear_drivers();
    for (int d = 0; d < 2; d++) begin
      if_on[d] = 1'b0; dm_on[d] = 1'b0;
      if_req[d] = 1'b0; dm_req[d] = 1'b0;
    end
  endtask

  task automatic run_cycles(input int n, input int prob, input bit allow_rst);
    int rst_done;
    rst_done = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      if (!reset) begin
        model_edge(0);
        model_edge(1);
      end
      #1;
      reset = 1'b0;
      check_cycle(0);
      check_cycle(1);
      // Abort the LAT=4 access while it sits in WAIT; both instances see the reset.
      if (allow_rst && rst_done < 8 && m_busy[1] && (cyc - m_tg[1] == 3) &&
          $urandom_range(3) == 0) begin
        rst_done++;
        #2 reset = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        check_cycle(0);
        check_cycle(1);
        clear_drivers();
      end else begin
        drive_next(0, prob);
        drive_next(1, prob);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      if_req[d] = 1'b0; if_addr[d] = '0;
      dm_req[d] = 1'b0; dm_we[d] = 1'b0; dm_addr[d] = '0; dm_wdata[d] = '0;
      din[d] = '0;
      model_reset(d);
    end
    clear_drivers();
    repeat (2) @(posedge clk);
    #1;
    check_cycle(0);
    check_cycle(1);
    // Both requesters raised together straight out of reset, held continuously.
    for (int d = 0; d < 2; d++) begin
      drive_next(d, 100);
    end
    run_cycles(80, 100, 1'b0);
    run_cycles(3000, 35, 1'b1);
    run_cycles(400, 100, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
